// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer for the E stage: latency counter, HI/LO ownership, mfhi/mflo/mthi/mtlo and D-stage stall.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are built when MDU_MACC_EN is defined.
module mdu_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op_type,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_mdu,
  output logic        start,
  output logic        busy,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall_req
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MFHI  = 4'd4;
  localparam logic [3:0] OP_MFLO  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd6;
  localparam logic [3:0] OP_MTLO  = 4'd7;
`ifdef MDU_MACC_EN
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
  localparam logic [3:0] OP_MSUBU = 4'd11;
`endif

  logic [0:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             busy_d;
  logic [31:0]      hi_d, lo_d;
  logic [31:0]      pend_hi, pend_lo, pend_hi_d, pend_lo_d;

  logic             is_mul, is_div, div_signed;
  logic [63:0]      prod_s, prod_u, res;
  logic [31:0]      a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  // Operation decode
  always_comb begin
    is_mul = (op_type == OP_MULT) || (op_type == OP_MULTU);
`ifdef MDU_MACC_EN
    is_mul = is_mul || (op_type == OP_MADD) || (op_type == OP_MADDU) ||
             (op_type == OP_MSUB) || (op_type == OP_MSUBU);
`endif
    is_div     = (op_type == OP_DIV) || (op_type == OP_DIVU);
    div_signed = (op_type == OP_DIV);
  end

  // Products are taken mod 2^64; sign-extending the operands yields the signed product
  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
  end

  // Sign-magnitude divide: quotient truncates toward zero, remainder follows a; 0x80000000/-1 falls out naturally
  always_comb begin
    a_mag  = (div_signed && a[31]) ? (~a + 32'd1) : a;
    b_mag  = (div_signed && b[31]) ? (~b + 32'd1) : b;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (div_signed && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
    rem    = (div_signed && a[31]) ? (~r_mag + 32'd1) : r_mag;
  end

  // Result selection; divide by zero carries the current HI/LO through to commit
  always_comb begin
    res = {hi, lo};
    case (op_type)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV, OP_DIVU: begin
        if (b != 32'd0) res = {rem, quo};
      end
`ifdef MDU_MACC_EN
      OP_MADD:  res = {hi, lo} + prod_s;
      OP_MADDU: res = {hi, lo} + prod_u;
      OP_MSUB:  res = {hi, lo} - prod_s;
      OP_MSUBU: res = {hi, lo} - prod_u;
`endif
      default:  res = {hi, lo};
    endcase
  end

  assign start     = op_valid && (state == S_IDLE) && (is_mul || is_div);
  assign stall_req = d_mdu && (start || busy);

  // HI/LO read port
  always_comb begin
    rdata = 32'd0;
    if (op_valid && !busy) begin
      if (op_type == OP_MFHI)      rdata = hi;
      else if (op_type == OP_MFLO) rdata = lo;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    busy_d    = busy;
    hi_d      = hi;
    lo_d      = lo;
    pend_hi_d = pend_hi;
    pend_lo_d = pend_lo;
    case (state)
      S_IDLE: begin
        if (start) begin
          pend_hi_d = res[63:32];
          pend_lo_d = res[31:0];
          cnt_d     = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          busy_d    = 1'b1;
          state_d   = S_RUN;
        end else if (op_valid) begin
          if (op_type == OP_MTHI)      hi_d = a;
          else if (op_type == OP_MTLO) lo_d = a;
        end
      end
      S_RUN: begin
        if (cnt == CNT_W'(1)) begin
          hi_d    = pend_hi;
          lo_d    = pend_lo;
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      busy    <= busy_d;
      hi      <= hi_d;
      lo      <= lo_d;
      pend_hi <= pend_hi_d;
      pend_lo <= pend_lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: table of mult/div vectors plus hand sequences for stall, reset and MACC.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [3:0]  op_type;
  logic [31:0] a, b;
  logic        d_mdu;
  logic        start, busy, stall_req;
  logic [31:0] rdata, hi, lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu_sequencer dut (
    .clk(clk), .reset(rst_n), .op_valid(op_valid), .op_type(op_type),
    .a(a), .b(b), .d_mdu(d_mdu), .start(start), .busy(busy),
    .rdata(rdata), .hi(hi), .lo(lo), .stall_req(stall_req)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp_start;
    int          exp_n;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op, then count busy cycles (bounded) and check the committed HI/LO
  task automatic run_mdu(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic exp_start, input int exp_n,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    @(negedge clk);
    op_valid = 1'b1; op_type = op; a = av; b = bv;
    #1 check("start", 32'(start), 32'(exp_start));
    @(posedge clk); #1 op_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(n), 32'(exp_n));
    check("hi", hi, exp_hi);
    check("lo", lo, exp_lo);
  endtask

  task automatic write_reg(input logic [3:0] op, input logic [31:0] val);
    @(negedge clk);
    op_valid = 1'b1; op_type = op; a = val;
    @(posedge clk); #1 op_valid = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [3:0] op, input logic [31:0] exp);
    @(negedge clk);
    op_valid = 1'b1; op_type = op;
    #1 check(name, rdata, exp);
    @(posedge clk); #1 op_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'd0, 32'hFFFFFFFE, 32'd3,        1'b1, 5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{4'd2, 32'hFFFFFFF9, 32'd2,        1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        1'b1, 10, 32'h00000001, 32'h7FFFFFFC};
    vecs[3] = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5,  32'hFFFFFFFE, 32'h00000001};
    vecs[4] = '{4'd0, 32'h80000000, 32'h80000000, 1'b1, 5,  32'h40000000, 32'h00000000};
    vecs[5] = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1, 10, 32'h00000000, 32'h80000000};
    vecs[6] = '{4'd2, 32'd7,        32'hFFFFFFFE, 1'b1, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[7] = '{4'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 10, 32'hFFFFFFFF, 32'h00000003};
    vecs[8] = '{4'd0, 32'h12345678, 32'h10,       1'b1, 5,  32'h00000001, 32'h23456780};

    rst_n = 1'b0; op_valid = 1'b0; op_type = 4'd0; a = 32'd0; b = 32'd0; d_mdu = 1'b1;

    // Reset state
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    d_mdu = 1'b0;
    rst_n = 1'b1;

    // Table of mult/div vectors
    for (int i = 0; i < 9; i++)
      run_mdu(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_start, vecs[i].exp_n,
              vecs[i].exp_hi, vecs[i].exp_lo);

    // MTHI/MTLO, MFHI/MFLO, divide by zero keeps HI/LO
    write_reg(4'd6, 32'h00001234);
    write_reg(4'd7, 32'h00005678);
    read_check("mfhi", 4'd4, 32'h00001234);
    read_check("mflo", 4'd5, 32'h00005678);
    run_mdu(4'd2, 32'd100, 32'd0, 1'b1, 10, 32'h00001234, 32'h00005678);
    run_mdu(4'd3, 32'd100, 32'd0, 1'b1, 10, 32'h00001234, 32'h00005678);

    // Reserved ops 12..15 do nothing
    for (int op = 12; op < 16; op++) begin
      @(negedge clk);
      op_valid = 1'b1; op_type = 4'(op); a = 32'hAAAAAAAA; b = 32'd3;
      #1 check("rsv_start", 32'(start), 32'd0);
      check("rsv_rdata", rdata, 32'd0);
      @(posedge clk); #1 op_valid = 1'b0;
      @(negedge clk);
      check("rsv_busy", 32'(busy), 32'd0);
      check("rsv_hi", hi, 32'h00001234);
      check("rsv_lo", lo, 32'h00005678);
    end

    // Stall window, ops ignored while busy (including the cnt==1 cycle), MFLO right after
    @(negedge clk);
    d_mdu = 1'b1; op_valid = 1'b1; op_type = 4'd0; a = 32'd3; b = 32'd4;
    #1 check("st_start", 32'(start), 32'd1);
    check("st_stall_T", 32'(stall_req), 32'd1);
    @(posedge clk); #1 op_type = 4'd6; a = 32'h0000DEAD;
    @(negedge clk); #1;
    check("st_busy_T1", 32'(busy), 32'd1);
    check("st_stall_T1", 32'(stall_req), 32'd1);
    check("st_rdata_mthi", rdata, 32'd0);
    @(posedge clk); #1 op_type = 4'd4;
    @(negedge clk); #1;
    check("st_mfhi_busy", rdata, 32'd0);
    check("st_hi_held", hi, 32'h00001234);
    check("st_stall_T2", 32'(stall_req), 32'd1);
    @(posedge clk); #1 op_valid = 1'b0;
    for (int k = 3; k < 5; k++) begin
      @(negedge clk); #1 check("st_stall_mid", 32'(stall_req), 32'd1);
    end
    @(negedge clk);
    op_valid = 1'b1; op_type = 4'd7; a = 32'h0000BEEF;
    #1 check("st_busy_T5", 32'(busy), 32'd1);
    check("st_stall_T5", 32'(stall_req), 32'd1);
    @(posedge clk); #1 op_type = 4'd5;
    @(negedge clk); #1;
    check("st_busy_T6", 32'(busy), 32'd0);
    check("st_stall_T6", 32'(stall_req), 32'd0);
    check("st_mflo", rdata, 32'd12);
    check("st_hi", hi, 32'd0);
    check("st_lo", lo, 32'd12);
    @(posedge clk); #1 op_valid = 1'b0; d_mdu = 1'b0;

    // Reset in the middle of a divide
    @(negedge clk);
    op_valid = 1'b1; op_type = 4'd2; a = 32'd100; b = 32'd7;
    @(posedge clk); #1 op_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_hi", hi, 32'd0);
    check("mr_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    read_check("mr_mfhi", 4'd4, 32'd0);
    repeat (12) @(negedge clk);
    check("mr_busy_after", 32'(busy), 32'd0);
    check("mr_hi_after", hi, 32'd0);
    check("mr_lo_after", lo, 32'd0);

    // Multiply-accumulate ops
    write_reg(4'd6, 32'd0);
    write_reg(4'd7, 32'hFFFFFFFF);
`ifdef MDU_MACC_EN
    run_mdu(4'd9,  32'd1, 32'd1, 1'b1, 5, 32'd1, 32'd0);
    run_mdu(4'd10, 32'd2, 32'd3, 1'b1, 5, 32'd0, 32'hFFFFFFFA);
`else
    run_mdu(4'd9,  32'd1, 32'd1, 1'b0, 0, 32'd0, 32'hFFFFFFFF);
    run_mdu(4'd10, 32'd2, 32'd3, 1'b0, 0, 32'd0, 32'hFFFFFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
